// File: rtl/ddr3_cmd_timing_ctrl.sv
// DDR3 command sequencer: accepts one command at a time, issues it to the driver, then
// holds the shared delay counter enabled until it reports done before accepting the next.
module ddr3_cmd_timing_ctrl #(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned T_RCD   = 5,
    parameter int unsigned T_CL    = 5,
    parameter int unsigned T_CWL   = 5,
    parameter int unsigned T_BURST = 4,
    parameter int unsigned T_WR    = 6,
    parameter int unsigned T_RP    = 5,
    parameter int unsigned T_RFC   = 44
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_code,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              cmd_ready,
    output logic              cmd_err,
    output logic              issue,
    output logic [2:0]        issue_code,
    output logic [ADDR_W-1:0] issue_addr,
    output logic              busy,
    output logic [15:0]       issued_cnt,
    output logic              cnt_en,
    output logic [31:0]       cnt_max,
    input  logic              cnt_done
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned ISSUED_W = 16;

    localparam int unsigned D_ACT = T_RCD;
    localparam int unsigned D_RD  = T_CL + T_BURST;
    localparam int unsigned D_WR  = T_CWL + T_BURST + T_WR;
    localparam int unsigned D_PRE = T_RP;
    localparam int unsigned D_REF = T_RFC;

    localparam logic [2:0] CODE_ACT = 3'd0;
    localparam logic [2:0] CODE_RD  = 3'd1;
    localparam logic [2:0] CODE_WR  = 3'd2;
    localparam logic [2:0] CODE_PRE = 3'd3;
    localparam logic [2:0] CODE_REF = 3'd4;

    // A delay below 2 would let done fire while still in ISSUE.
    if (D_ACT < 2 || D_RD < 2 || D_WR < 2 || D_PRE < 2 || D_REF < 2) begin : g_bad_delay
        $error("ddr3_cmd_timing_ctrl: every derived delay must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              legal_c;
    logic [CNT_W-1:0]  delay_c;
    logic              accept_c;
    logic              err_c;

    // Delay lookup for the offered code.
    always_comb begin
        legal_c = 1'b1;
        delay_c = '0;
        case (cmd_code)
            CODE_ACT: delay_c = CNT_W'(D_ACT);
            CODE_RD:  delay_c = CNT_W'(D_RD);
            CODE_WR:  delay_c = CNT_W'(D_WR);
            CODE_PRE: delay_c = CNT_W'(D_PRE);
            CODE_REF: delay_c = CNT_W'(D_REF);
            default:  legal_c = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; done is only honoured in WAIT.
    always_comb begin
        state_nx = state;
        accept_c = 1'b0;
        err_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (legal_c) begin
                        accept_c = 1'b1;
                        state_nx = S_ISSUE;
                    end else begin
                        err_c = 1'b1;
                    end
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (cnt_done) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_ready  <= 1'b1;
            cmd_err    <= 1'b0;
            issue      <= 1'b0;
            busy       <= 1'b0;
            cnt_en     <= 1'b0;
            issue_code <= '0;
            issue_addr <= '0;
            cnt_max    <= '0;
            issued_cnt <= '0;
        end else begin
            cmd_ready <= (state_nx == S_IDLE);
            cmd_err   <= err_c;
            issue     <= (state_nx == S_ISSUE);
            busy      <= (state_nx != S_IDLE);
            cnt_en    <= (state_nx != S_IDLE);
            if (accept_c) begin
                issue_code <= cmd_code;
                issue_addr <= cmd_addr;
                cnt_max    <= delay_c;
                issued_cnt <= issued_cnt + ISSUED_W'(1);
            end
        end
    end

endmodule
